btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Sequences all writes into the branch target buffer (BTB) on behalf of the execute stage.
- Queues resolved-branch updates and probes the BTB to decide between allocate, rewrite, invalidate or drop.
- Owns the round-robin replacement pointer.
- Runs a one-entry-per-cycle invalidate walk on a flush request (fence.i, context change).
- Sits between the EXE-stage branch resolver and the BTB write and probe ports.

Parameters:
- BLOCKSIZE, 4, number of BTB entries; power of two, at least 2.
- IDXW, 2, entry index width; equals log2(BLOCKSIZE).
- QDEPTH, 2, depth of the update queue; power of two.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- upd_valid  in  1  EXE presents a resolved branch.
- upd_ready  out  1  queue can accept an update this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_target  in  32  computed target (pc+imm).
- upd_taken  in  1  branch resolved taken.
- flush_req  in  1  one-cycle pulse requesting invalidation of every BTB entry.
- flush_done  out  1  one-cycle pulse when the invalidate walk completes.
- busy  out  1  high whenever state is not IDLE or the queue is non-empty.
- probe_pc  out  32  PC looked up on the BTB probe port (combinational lookup).
- probe_hit  in  1  BTB contains a valid entry for probe_pc.
- probe_idx  in  IDXW  index of the matching entry; don't-care on miss.
- wr_en  out  1  BTB write strobe.
- wr_idx  out  IDXW  entry to write.
- wr_pc  out  32  tag written.
- wr_target  out  32  target written.
- wr_valid  out  1  valid bit written.

Behaviour:
- Reset:
  - state=IDLE; queue empty; alloc_ptr=0; flush_pend=0.
  - wr_en, wr_idx, wr_pc, wr_target, wr_valid, flush_done, busy and probe_pc are all 0.
  - upd_ready=1 from the first cycle after reset deassertion.
  - Reset mid-walk or mid-write aborts immediately; a partially walked BTB is left as-is.
- Queue:
  - Push on upd_valid & upd_ready.
  - upd_ready = !full & !flush_pend & (state!=FLUSH).
  - Push and pop in the same cycle are legal.
  - The pointers wrap modulo QDEPTH.
- Flush latch: a flush_req pulse sets flush_pend. flush_req while state==FLUSH is ignored.
- FSM:
  - IDLE:
    - If flush_pend, discard queue contents (stale) and go to FLUSH with walk_idx=0.
    - Else if queue non-empty, go to PROBE.
    - Flush has priority over queued updates.
  - PROBE (1 cycle):
    - probe_pc=head.pc; register probe_hit and probe_idx; decide:
    - taken & miss: write at alloc_ptr, wr_valid=1, then alloc_ptr+1 (wraps mod BLOCKSIZE).
    - taken & hit: rewrite target at probe_idx, wr_valid=1; alloc_ptr unchanged.
    - not-taken & hit: invalidate at probe_idx, wr_valid=0.
    - not-taken & miss: pop and return to IDLE; no write.
    - Otherwise go to WRITE.
  - WRITE (1 cycle): wr_en=1 with the registered idx, head.pc, head.target and valid. Pop the head. Next state is IDLE.
  - FLUSH:
    - Each cycle: wr_en=1, wr_idx=walk_idx, wr_valid=0, wr_pc=0, wr_target=0; walk_idx increments.
    - On walk_idx==BLOCKSIZE-1, next state is IDLE, flush_done=1 for that next cycle, alloc_ptr=0 and flush_pend=0.
  - A flush_req arriving during PROBE or WRITE lets the current update finish, then FLUSH is entered from IDLE.
- Latency:
  - Update pushed at cycle N: PROBE at N+1, wr_en at N+2.
  - Back-to-back throughput is one update per 3 cycles (IDLE, PROBE, WRITE).
  - Flush takes BLOCKSIZE write cycles, plus one IDLE cycle if it is latched while idle.
- Outputs are registered except probe_pc and upd_ready. wr_en is never asserted outside the WRITE and FLUSH states.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, PROBE=2'd1, WRITE=2'd2, FLUSH=2'd3.
  - An update-record struct {pc[31:0], target[31:0], taken}.
  - The BTB default BLOCKSIZE.
- One sub-module, btb_upd_fifo: a QDEPTH-deep synchronous FIFO with full, empty, push, pop and head outputs, reset by rst.

Test Plan:
- Alloc on taken-miss:
  - Stimulus: after reset, push pc=0x100, target=0x140, taken=1, probe_hit=0.
  - Response: two cycles later, one wr_en with idx=0, pc=0x100, target=0x140, valid=1; alloc_ptr becomes 1.
- Rewrite, invalidate and drop:
  - Push taken pc=0x100 with probe_hit=1, idx=2 and target 0x180 → write at idx 2 with target 0x180, valid=1; alloc_ptr unchanged.
  - Push not-taken with probe_hit=1, idx=2 → write at idx 2, valid=0.
  - Push not-taken with miss → no wr_en, busy drops.
- Wrap-around: five taken-miss updates → wr_idx sequence 0,1,2,3,0.
- Queue full:
  - Hold upd_valid=1 with QDEPTH=2 and updates arriving every cycle → upd_ready falls after 2 accepts.
  - No update is lost; three writes complete in order.
- Flush walk:
  - flush_req while 1 update is queued and 1 is in WRITE → in-flight write completes, queued update is discarded.
  - Then wr_en for idx 0,1,2,3 with valid=0, then flush_done pulse; upd_ready is low throughout.
- Reset mid-flush: assert rst during walk_idx=2 → all outputs are 0 immediately, upd_ready=1 after deassertion.

Source files
------------

// File: rtl/btb_update_ctrl_pkg.sv
// Shared types for the BTB update controller: FSM encoding, queued update record
// and the default BTB size.
package btb_update_ctrl_pkg;

  localparam int unsigned BTB_BLOCKSIZE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_rec_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates; clear drops every entry.
module btb_upd_fifo
  import btb_update_ctrl_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     clear,
  input  upd_rec_t din,
  output upd_rec_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  upd_rec_t      mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(QDEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences BTB writes: queued branch updates (probe, then allocate/rewrite/invalidate/drop)
// and the one-entry-per-cycle invalidate walk on flush.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int unsigned BLOCKSIZE = BTB_BLOCKSIZE,
  parameter int unsigned IDXW      = 2,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [31:0]     upd_pc,
  input  logic [31:0]     upd_target,
  input  logic            upd_taken,
  input  logic            flush_req,
  output logic            flush_done,
  output logic            busy,
  output logic [31:0]     probe_pc,
  input  logic            probe_hit,
  input  logic [IDXW-1:0] probe_idx,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_idx,
  output logic [31:0]     wr_pc,
  output logic [31:0]     wr_target,
  output logic            wr_valid
);

  state_t          state;
  logic            flush_pend;
  logic [IDXW-1:0] alloc_ptr;
  logic [IDXW-1:0] walk_idx;
  upd_rec_t        din;
  upd_rec_t        head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            clear;

  assign upd_ready = !full && !flush_pend && (state != FLUSH);
  assign push      = upd_valid && upd_ready;
  assign pop       = (state == WRITE) || ((state == PROBE) && !head.taken && !probe_hit);
  assign clear     = (state == IDLE) && flush_pend;
  assign din       = '{pc: upd_pc, target: upd_target, taken: upd_taken};
  assign probe_pc  = (state == PROBE) ? head.pc : '0;
  assign busy      = (state != IDLE) || !empty;

  btb_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Write-port outputs are loaded on the edge entering WRITE/FLUSH so they are
  // valid for exactly the cycles spent in those states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      alloc_ptr  <= '0;
      walk_idx   <= '0;
      wr_en      <= 1'b0;
      wr_idx     <= '0;
      wr_pc      <= '0;
      wr_target  <= '0;
      wr_valid   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      wr_idx     <= '0;
      wr_pc      <= '0;
      wr_target  <= '0;
      wr_valid   <= 1'b0;
      flush_done <= 1'b0;
      if (flush_req && (state != FLUSH)) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (flush_pend) begin
            state    <= FLUSH;
            walk_idx <= '0;
            wr_en    <= 1'b1;
          end else if (!empty || push) begin
            state <= PROBE;
          end
        end
        PROBE: begin
          if (head.taken || probe_hit) begin
            state     <= WRITE;
            wr_en     <= 1'b1;
            wr_pc     <= head.pc;
            wr_target <= head.target;
            wr_valid  <= head.taken;
            if (probe_hit) begin
              wr_idx <= probe_idx;
            end else begin
              wr_idx    <= alloc_ptr;
              alloc_ptr <= (alloc_ptr == IDXW'(BLOCKSIZE - 1)) ? '0 : alloc_ptr + 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WRITE: state <= IDLE;
        FLUSH: begin
          if (walk_idx == IDXW'(BLOCKSIZE - 1)) begin
            state      <= IDLE;
            flush_done <= 1'b1;
            alloc_ptr  <= '0;
            flush_pend <= 1'b0;
          end else begin
            walk_idx <= walk_idx + 1'b1;
            wr_en    <= 1'b1;
            wr_idx   <= walk_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: expected BTB writes are queued at stimulus
// time and matched against wr_* on every wr_en cycle.
module tb_btb_update_ctrl;

  localparam int unsigned BLOCKSIZE = 4;
  localparam int unsigned IDXW      = 2;
  localparam int unsigned QDEPTH    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            upd_valid = 1'b0;
  logic            upd_ready;
  logic [31:0]     upd_pc = '0;
  logic [31:0]     upd_target = '0;
  logic            upd_taken = 1'b0;
  logic            flush_req = 1'b0;
  logic            flush_done;
  logic            busy;
  logic [31:0]     probe_pc;
  logic            probe_hit = 1'b0;
  logic [IDXW-1:0] probe_idx = '0;
  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [31:0]     wr_pc;
  logic [31:0]     wr_target;
  logic            wr_valid;

  always #5 clk = ~clk;

  btb_update_ctrl #(.BLOCKSIZE(BLOCKSIZE), .IDXW(IDXW), .QDEPTH(QDEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .busy       (busy),
    .probe_pc   (probe_pc),
    .probe_hit  (probe_hit),
    .probe_idx  (probe_idx),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_pc      (wr_pc),
    .wr_target  (wr_target),
    .wr_valid   (wr_valid)
  );

  typedef struct {
    logic [IDXW-1:0] idx;
    logic [31:0]     pc;
    logic [31:0]     target;
    logic            valid;
  } wr_t;

  wr_t             exp_q[$];
  wr_t             mon_e;
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [IDXW-1:0] alloc_m = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 64'(wr_en), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_idx", 64'(wr_idx), 64'(mon_e.idx));
        chk("wr_pc", 64'(wr_pc), 64'(mon_e.pc));
        chk("wr_target", 64'(wr_target), 64'(mon_e.target));
        chk("wr_valid", 64'(wr_valid), 64'(mon_e.valid));
      end
    end
  end

  // Reference decision for one update, in queue order.
  task automatic sb_push(input logic [31:0] pc, input logic [31:0] target, input logic taken,
                         input logic hit, input logic [IDXW-1:0] idx);
    if (hit) begin
      exp_q.push_back('{idx: idx, pc: pc, target: target, valid: taken});
    end else if (taken) begin
      exp_q.push_back('{idx: alloc_m, pc: pc, target: target, valid: 1'b1});
      alloc_m = alloc_m + 1'b1;
    end
  endtask

  task automatic sb_flush();
    for (int unsigned i = 0; i < BLOCKSIZE; i++)
      exp_q.push_back('{idx: IDXW'(i), pc: '0, target: '0, valid: 1'b0});
    alloc_m = '0;
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (!upd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!upd_ready) chk(tag, 64'(upd_ready), 64'(1));
  endtask

  task automatic push_upd(input logic [31:0] pc, input logic [31:0] target, input logic taken,
                          input logic hit, input logic [IDXW-1:0] idx);
    upd_pc     = pc;
    upd_target = target;
    upd_taken  = taken;
    probe_hit  = hit;
    probe_idx  = idx;
    upd_valid  = 1'b1;
    wait_ready("push_timeout");
    sb_push(pc, target, taken, hit, idx);
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_busy", 64'(busy), 64'(0));
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int unsigned n;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_idx", 64'(wr_idx), 64'(0));
    chk("rst_wr_pc", 64'(wr_pc), 64'(0));
    chk("rst_wr_target", 64'(wr_target), 64'(0));
    chk("rst_wr_valid", 64'(wr_valid), 64'(0));
    chk("rst_flush_done", 64'(flush_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_probe_pc", 64'(probe_pc), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_upd_ready", 64'(upd_ready), 64'(1));

    // Allocate on taken-miss, with latency checks
    push_upd(32'h100, 32'h140, 1'b1, 1'b0, '0);
    chk("probe_pc", 64'(probe_pc), 64'(32'h100));
    @(posedge clk); #1;
    chk("lat_wr_en", 64'(wr_en), 64'(1));
    wait_idle();

    // Rewrite, invalidate, drop, then allocation continues at 1
    push_upd(32'h100, 32'h180, 1'b1, 1'b1, 2'd2);
    wait_idle();
    push_upd(32'h100, 32'h180, 1'b0, 1'b1, 2'd2);
    wait_idle();
    push_upd(32'h200, 32'h240, 1'b0, 1'b0, 2'd3);
    wait_idle();
    push_upd(32'h300, 32'h340, 1'b1, 1'b0, '0);
    wait_idle();

    // Queue full: upd_valid held every cycle
    probe_hit = 1'b0;
    upd_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_pc     = 32'h400 + 32'(i * 16);
      upd_target = 32'h800 + 32'(i * 16);
      upd_valid  = 1'b1;
      wait_ready("full_timeout");
      sb_push(upd_pc, upd_target, 1'b1, 1'b0, '0);
      @(posedge clk); #1;
      if (i == 1) chk("full_ready", 64'(upd_ready), 64'(0));
    end
    upd_valid = 1'b0;
    wait_idle();

    // Flush with one update in flight and one queued
    upd_pc = 32'h500; upd_target = 32'h540; upd_taken = 1'b1; probe_hit = 1'b0;
    upd_valid = 1'b1;
    chk("fl_ready_a", 64'(upd_ready), 64'(1));
    sb_push(32'h500, 32'h540, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    upd_pc = 32'h600; upd_target = 32'h640;
    chk("fl_ready_b", 64'(upd_ready), 64'(1));
    @(posedge clk); #1;
    upd_valid = 1'b0;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    sb_flush();
    n = 0;
    while (!flush_done && n < 20) begin
      chk("flush_ready", 64'(upd_ready), 64'(0));
      @(posedge clk); #1;
      n++;
    end
    chk("flush_done", 64'(flush_done), 64'(1));
    chk("flush_sb", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
    chk("done_pulse", 64'(flush_done), 64'(0));
    wait_idle();

    // Wrap-around: allocation restarts at 0 after flush
    for (int i = 0; i < 5; i++)
      push_upd(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4), 1'b1, 1'b0, '0);
    wait_idle();

    // Reset in the middle of the invalidate walk
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    exp_q.push_back('{idx: 2'd0, pc: '0, target: '0, valid: 1'b0});
    exp_q.push_back('{idx: 2'd1, pc: '0, target: '0, valid: 1'b0});
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("walk2_en", 64'(wr_en), 64'(1));
    chk("walk2_idx", 64'(wr_idx), 64'(2));
    rst = 1'b1;
    #1;
    chk("mid_wr_en", 64'(wr_en), 64'(0));
    chk("mid_wr_idx", 64'(wr_idx), 64'(0));
    chk("mid_wr_valid", 64'(wr_valid), 64'(0));
    chk("mid_flush_done", 64'(flush_done), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_probe_pc", 64'(probe_pc), 64'(0));
    chk("mid_sb", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_ready", 64'(upd_ready), 64'(1));
    alloc_m = '0;
    push_upd(32'h3000, 32'h3040, 1'b1, 1'b0, '0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
